// File: rtl/ram_sp_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a
// one-cycle synchronous read. At most one access is granted per cycle; when
// both ports contend, a 1-bit priority pointer picks the winner and then
// flips to the loser. Read data is steered back to the port that issued the
// read, using a small state register that remembers who read last cycle.
module ram_sp_arbiter #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  // requester 0
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] din0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DWIDTH-1:0] rdata0,
  // requester 1
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] din1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata1,
  // RAM side
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD0  = 2'd1;
  localparam logic [1:0] ST_RD1  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  // prio names the port that wins when both request (0 or 1)
  logic       prio;

  // Grant: a lone request wins, contention goes to prio; nothing is granted in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || !prio)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // RAM port follows the granted requester, and is driven to zero when idle
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (gnt0) begin
      ram_addr = addr0;
      ram_din  = din0;
      ram_we   = we0;
    end else if (gnt1) begin
      ram_addr = addr1;
      ram_din  = din1;
      ram_we   = we1;
    end
  end

  // Next state depends only on this cycle's accepted access, never on the current state
  always_comb begin
    state_nxt = ST_IDLE;
    if (gnt0 && !we0) begin
      state_nxt = ST_RD0;
    end else if (gnt1 && !we1) begin
      state_nxt = ST_RD1;
    end
  end

  // Read-owner state and priority pointer; the pointer moves to the loser after each grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt0) begin
        prio <= 1'b1;
      end else if (gnt1) begin
        prio <= 1'b0;
      end
    end
  end

  // Read return: RAM data lands the cycle after the read, routed to its owner and zeroed otherwise
  always_comb begin
    rvalid0 = (state == ST_RD0);
    rvalid1 = (state == ST_RD1);
    rdata0  = rvalid0 ? ram_dout : '0;
    rdata1  = rvalid1 ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: a behavioural sync-read RAM, a transaction-level
// reference model, a directed vector table, hand-written reset/contention
// sequences and a randomized phase that honours the hold-until-granted rule.
module tb_ram_sp_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  int vectors = 0;
  int fails   = 0;

  ram_sp_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Environment RAM: synchronous read, one cycle of latency
  logic [DW-1:0] tb_mem [0:7] = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'hA5A5_A5A5,
                                  32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
  always @(posedge clock) begin
    if (ram_we) tb_mem[ram_addr] <= ram_din;
    ram_dout <= tb_mem[ram_addr];
  end

  // Reference model: memory contents, favoured port, and the read due back next cycle
  logic [DW-1:0] ref_mem [0:7] = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'hA5A5_A5A5,
                                   32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
  int            m_prio;
  bit            m_rv0, m_rv1, n_rv0, n_rv1;
  logic [DW-1:0] m_rd0, m_rd1, n_rd0, n_rd1;
  bit            last_g0, last_g1;

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, v0, v1;
    logic [DW-1:0] q0, q1;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic g0, logic g1, logic v0, logic v1,
                              logic [DW-1:0] q0, logic [DW-1:0] q1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_rv0 = 0; m_rv1 = 0; n_rv0 = 0; n_rv1 = 0;
    m_rd0 = '0; m_rd1 = '0; n_rd0 = '0; n_rd1 = '0;
    last_g0 = 0; last_g1 = 0;
  endtask

  // Compare every output against the model mid-cycle, then retire this cycle's access
  task automatic check_half();
    bit            e_g0, e_g1, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    @(negedge clock);
    e_g0 = !reset && req0 && (!req1 || m_prio == 0);
    e_g1 = !reset && req1 && (!req0 || m_prio == 1);
    e_we = 0; e_addr = '0; e_din = '0;
    if (e_g0) begin e_we = we0; e_addr = addr0; e_din = din0; end
    if (e_g1) begin e_we = we1; e_addr = addr1; e_din = din1; end
    chk("gnt0", 32'(gnt0), 32'(e_g0));
    chk("gnt1", 32'(gnt1), 32'(e_g1));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_din", ram_din, e_din);
    chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
    chk("rdata0", rdata0, m_rv0 ? m_rd0 : 32'h0);
    chk("rdata1", rdata1, m_rv1 ? m_rd1 : 32'h0);
    n_rv0 = e_g0 && !we0; n_rd0 = ref_mem[addr0];
    n_rv1 = e_g1 && !we1; n_rd1 = ref_mem[addr1];
    if (e_g0 && we0) ref_mem[addr0] = din0;
    if (e_g1 && we1) ref_mem[addr1] = din1;
    if (e_g0) m_prio = 1;
    else if (e_g1) m_prio = 0;
    last_g0 = e_g0; last_g1 = e_g1;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    m_rv0 = n_rv0; m_rd0 = n_rd0; n_rv0 = 0;
    m_rv1 = n_rv1; m_rd1 = n_rd1; n_rv1 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    model_reset();

    // Reset state, before any clock edge
    #2;
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_gnt0_with_req", 32'(gnt0), 32'd0);
    do_reset();

    // Directed vector table
    tbl[0]  = mk(1,0,3'd3,0,            0,0,3'd0,0,            1,0,0,0, 32'h0, 32'h0);
    tbl[1]  = mk(0,0,3'd0,0,            0,0,3'd0,0,            0,0,1,0, 32'hA5A5_A5A5, 32'h0);
    tbl[2]  = mk(1,0,3'd2,0,            1,0,3'd7,0,            0,1,0,0, 32'h0, 32'h0);
    tbl[3]  = mk(1,0,3'd2,0,            1,0,3'd7,0,            1,0,0,1, 32'h0, 32'h7777_7777);
    tbl[4]  = mk(1,0,3'd2,0,            1,0,3'd7,0,            0,1,1,0, 32'h2222_2222, 32'h0);
    tbl[5]  = mk(0,0,3'd0,0,            0,0,3'd0,0,            0,0,0,1, 32'h0, 32'h7777_7777);
    tbl[6]  = mk(0,0,3'd0,0,            1,1,3'd5,32'h1234_5678, 0,1,0,0, 32'h0, 32'h0);
    tbl[7]  = mk(0,0,3'd0,0,            1,0,3'd5,0,            0,1,0,0, 32'h0, 32'h0);
    tbl[8]  = mk(0,0,3'd0,0,            0,0,3'd0,0,            0,0,0,1, 32'h0, 32'h1234_5678);
    tbl[9]  = mk(1,1,3'd2,32'hDEAD_BEEF, 1,0,3'd2,0,           1,0,0,0, 32'h0, 32'h0);
    tbl[10] = mk(0,0,3'd0,0,            1,0,3'd2,0,            0,1,0,0, 32'h0, 32'h0);
    tbl[11] = mk(0,0,3'd0,0,            0,0,3'd0,0,            0,0,0,1, 32'h0, 32'hDEAD_BEEF);
    for (int i = 12; i < 16; i++)
      tbl[i] = mk(0,0,3'd0,0,           0,0,3'd0,0,            0,0,0,0, 32'h0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      check_half();
      chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].v0));
      chk($sformatf("tbl%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d_rdata0", i), rdata0, tbl[i].q0);
      chk($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].q1);
      advance();
    end

    // Sustained contention right after reset alternates grants starting with port 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 3'd1, '0, 1, 0, 3'd6, '0);
      check_half();
      chk($sformatf("alt%0d_gnt0", i), 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_addr", i), 32'(ram_addr), (i % 2 == 0) ? 32'd1 : 32'd6);
      chk($sformatf("alt%0d_both", i), 32'(rvalid0 & rvalid1), 32'd0);
      advance();
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    check_half();
    advance();

    // Reset asserted while a read result is being presented clears it at once
    drive(1, 0, 3'd3, '0, 0, 0, '0, '0);
    check_half();
    advance();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    chk("rd_before_reset_rvalid0", 32'(rvalid0), 32'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("async_rst_rdata0", rdata0, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Read accepted, then reset before the next edge: no rvalid ever appears
    drive(1, 0, 3'd3, '0, 0, 0, '0, '0);
    check_half();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    drive(1, 1, 3'd4, 32'hFFFF_0000, 1, 1, 3'd4, 32'h0000_FFFF);
    #1;
    chk("rst_ram_we_wr", 32'(ram_we), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    advance();
    chk("lost_read_rvalid0", 32'(rvalid0), 32'd0);
    reset = 1'b0;
    drive(1, 0, 3'd0, '0, 1, 0, 3'd1, '0);
    check_half();
    chk("post_rst_gnt0", 32'(gnt0), 32'd1);
    chk("post_rst_rvalid0", 32'(rvalid0), 32'd0);
    advance();

    // Randomized traffic; an ungranted requester keeps its request stable
    for (int i = 0; i < 500; i++) begin
      if (!(req0 && !last_g0)) begin
        req0 = ($urandom_range(0, 3) != 0);
        we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 7));
        din0 = $urandom;
      end
      if (!(req1 && !last_g1)) begin
        req1 = ($urandom_range(0, 3) != 0);
        we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 7));
        din1 = $urandom;
      end
      check_half();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/ram_sp_arbiter.md
RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 3, meaning RAM address width (depth = 2^AWIDTH).
REQ-002 The block SHALL have parameter DWIDTH, default 32, meaning RAM data width.
REQ-003 Port clock: input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1 bit, asynchronous, active-high reset.
REQ-005 Port req0: input, 1 bit, requester 0 access request.
REQ-006 Port we0: input, 1 bit, requester 0 write (1) or read (0).
REQ-007 Port addr0: input, AWIDTH bits, requester 0 address.
REQ-008 Port din0: input, DWIDTH bits, requester 0 write data.
REQ-009 Port gnt0: output, 1 bit, requester 0 access accepted this cycle.
REQ-010 Port rvalid0: output, 1 bit, requester 0 read data valid.
REQ-011 Port rdata0: output, DWIDTH bits, requester 0 read data.
REQ-012 Ports req1, we1, addr1, din1, gnt1, rvalid1 and rdata1 SHALL be identical to the requester 0 ports, for requester 1.
REQ-013 Port ram_addr: output, AWIDTH bits, address to the single-port sync-read RAM.
REQ-014 Port ram_din: output, DWIDTH bits, write data to the RAM.
REQ-015 Port ram_we: output, 1 bit, RAM write enable.
REQ-016 Port ram_dout: input, DWIDTH bits, RAM read data, valid the cycle after the address edge.

Function
REQ-017 The block SHALL accept at most one access per cycle.
- An access is accepted when reqN=1 and gntN=1.
- gntN is combinational from the reqN inputs and the registered priority pointer.
REQ-018 Arbitration SHALL be round-robin using a 1-bit pointer prio.
- Only one request pending: grant it.
- Both pending: grant the port equal to prio.
- Neither pending: no grant.
REQ-019 After each accepted access, prio SHALL toggle to the port not granted.
- With no grant, prio SHALL hold its value.
REQ-020 During a grant, the RAM outputs SHALL follow the granted port's inputs.
- ram_addr = addrN, ram_din = dinN, ram_we = weN.
REQ-021 With no grant, ram_we SHALL be 0 and ram_addr/ram_din SHALL be 0.
REQ-022 An accepted read (weN=0) SHALL give 1-cycle latency.
- On the next cycle: rvalidN=1 for exactly one cycle and rdataN=ram_dout.
REQ-023 rvalidN SHALL be 0 after an accepted write and after a cycle with no grant.
REQ-024 rdataN SHALL be 0 whenever rvalidN=0.
REQ-025 The block SHALL use a registered state machine with three states.
- IDLE: previous cycle had no read accepted.
- RD0: previous cycle accepted a read from port 0.
- RD1: previous cycle accepted a read from port 1.
REQ-026 Each cycle's next state SHALL be set by that cycle's accepted access, independent of the current state.
- Read from port 0 -> RD0.
- Read from port 1 -> RD1.
- Write or no grant -> IDLE.
REQ-027 rvalid0 SHALL equal (state==RD0) and rvalid1 SHALL equal (state==RD1).
- Back-to-back reads and read-then-write SHALL run at full rate with no bubble.
REQ-028 A write followed by a read of the same address on the next cycle SHALL return the newly written data; no forwarding logic is required.
REQ-029 A request not granted SHALL stay pending until granted.
- The requester holds req, we, addr and din stable until grant; the block does not buffer them.
REQ-030 Sustained requests on both ports SHALL alternate grants, so each port waits at most 1 cycle.

Reset
REQ-031 Asserting reset SHALL immediately, without waiting for a clock edge, force:
- state = IDLE and prio = 0;
- rvalid0 = rvalid1 = 0 and rdata0 = rdata1 = 0.
REQ-032 A read accepted in the cycle before reset asserts SHALL produce no rvalid.
REQ-033 While reset is high, gnt0, gnt1 and ram_we SHALL be 0.
REQ-034 Arbitration SHALL resume on the first rising edge after reset deasserts, with port 0 favoured.

Verification
REQ-035 Reset, then req0 read addr 3 alone; RAM[3]=0xA5A5A5A5 -> gnt0=1 same cycle; next cycle rvalid0=1, rdata0=0xA5A5A5A5, rvalid1=0.
REQ-036 Both ports request every cycle for 6 cycles after reset -> grant order 0,1,0,1,0,1; ram_addr alternates between addr0 and addr1.
REQ-037 Port 1 writes 0x12345678 to addr 5, then reads addr 5 on the next cycle -> rvalid1=1 with 0x12345678; no rvalid after the write cycle.
REQ-038 Port 0 reads addr 2 and port 1 reads addr 7 on back-to-back cycles -> rvalid0 then rvalid1 on consecutive cycles with the correct data; never both high.
REQ-039 Accept a port-0 read, then assert reset mid-cycle before the next edge -> rvalid0 stays 0; after release, a simultaneous request grants port 0.
REQ-040 No requests for 4 cycles -> ram_we=0, gnt0=gnt1=0, rvalid0=rvalid1=0, and prio unchanged.
